// File: rtl/pe_demux.sv
// 1->N operand distributor: steers one valid/ready input word per cycle into one of
// 2**SEL_WIDTH single-entry lane registers. Optional broadcast via PE_DEMUX_BCAST_EN.
module pe_demux #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SEL_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [SEL_WIDTH-1:0]            in_sel,
  input  logic                            in_auto,
`ifdef PE_DEMUX_BCAST_EN
  input  logic                            in_bcast,
`endif
  output logic [(2**SEL_WIDTH)-1:0]       out_valid,
  input  logic [(2**SEL_WIDTH)-1:0]       out_ready,
  output logic [(2**SEL_WIDTH)*WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]            rr_ptr,
  output logic                            frame_done
);

  localparam int unsigned N_IN = 2**SEL_WIDTH;

  logic [1:0]           rst_sync;
  logic                 rst_int_n;
  logic [N_IN-1:0]      lane_free;
  logic [N_IN-1:0]      wr_en;
  logic [SEL_WIDTH-1:0] tgt;
  logic                 bcast;
  logic                 accept;
  logic                 auto_acc;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

`ifdef PE_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign lane_free = ~out_valid | out_ready;
  assign tgt       = in_auto ? rr_ptr : in_sel;

  always_comb begin
    in_ready = 1'b0;
    if (rst_int_n) in_ready = bcast ? (&lane_free) : lane_free[tgt];
  end

  assign accept   = in_valid && in_ready;
  assign auto_acc = accept && in_auto && !bcast;

  always_comb begin
    wr_en = '0;
    if (accept) begin
      if (bcast) wr_en = '1;
      else       wr_en[tgt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (wr_en[i]) begin
          out_valid[i]                <= 1'b1;
          out_data[i*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rr_ptr     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= auto_acc && (rr_ptr == SEL_WIDTH'(N_IN - 1));
      if (auto_acc) rr_ptr <= rr_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_demux.sv
// Directed self-checking bench for pe_demux (default 8-bit, 8-lane build).
module tb_pe_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_auto;
`ifdef PE_DEMUX_BCAST_EN
  logic        in_bcast;
`endif
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
  logic [2:0]  rr_ptr;
  logic        frame_done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pe_demux #(.WIDTH(8), .SEL_WIDTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_auto    (in_auto),
`ifdef PE_DEMUX_BCAST_EN
    .in_bcast   (in_bcast),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rr_ptr     (rr_ptr),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] lane(input int unsigned i);
    return out_data[i*8 +: 8];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_auto = 1'b0;
    out_ready = '0;
`ifdef PE_DEMUX_BCAST_EN
    in_bcast = 1'b0;
`endif
    repeat (3) tick();
    check("rst_valid", out_valid, 64'h0);
    check("rst_data", out_data, 64'h0);
    check("rst_ptr", rr_ptr, 64'h0);
    check("rst_fd", frame_done, 64'h0);
    check("rst_ready", in_ready, 64'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Addressed write to lane 3
    in_valid = 1'b1; in_auto = 1'b0; in_sel = 3'd3; in_data = 8'hA5;
    #1 check("addr_ready", in_ready, 64'h1);
    tick();
    check("addr_valid", out_valid, 64'h08);
    check("addr_data", lane(3), 64'hA5);
    in_data = 8'h5A;
    #1 check("addr_full_ready", in_ready, 64'h0);
    tick();
    check("addr_hold_valid", out_valid, 64'h08);
    check("addr_hold_data", lane(3), 64'hA5);
    in_valid = 1'b0; out_ready = 8'hFF;
    tick();
    check("drain_valid", out_valid, 64'h00);
    check("drain_data_kept", lane(3), 64'hA5);
    check("addr_ptr", rr_ptr, 64'h0);

    // Auto frame, back-to-back
    in_auto = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      #1 check("auto_ready", in_ready, 64'h1);
      check("auto_ptr", rr_ptr, 64'(i));
      tick();
      check("auto_valid", out_valid, 64'(8'h01 << i));
      check("auto_data", lane(i), 64'(8'h10 + i));
      check("auto_fd", frame_done, (i == 7) ? 64'h1 : 64'h0);
    end
    in_valid = 1'b0;
    check("frame_ptr_wrap", rr_ptr, 64'h0);
    tick();
    check("fd_one_pulse", frame_done, 64'h0);
    check("frame_drained", out_valid, 64'h00);

    // Full-lane stall on lane 0
    out_ready = 8'hFE; in_auto = 1'b0; in_sel = 3'd0; in_data = 8'h30; in_valid = 1'b1;
    tick();
    in_auto = 1'b1; in_data = 8'h31;
    #1 check("stall_ready", in_ready, 64'h0);
    tick();
    check("stall_ptr", rr_ptr, 64'h0);
    check("stall_data", lane(0), 64'h30);
    check("stall_valid", out_valid, 64'h01);
    out_ready = 8'hFF;
    #1 check("unstall_ready", in_ready, 64'h1);
    tick();
    check("refill_valid", out_valid, 64'h01);
    check("refill_data", lane(0), 64'h31);
    check("refill_ptr", rr_ptr, 64'h1);
    in_valid = 1'b0;
    tick();

    // Reset mid-operation with lanes 2 and 5 loaded
    out_ready = 8'h00; in_auto = 1'b0; in_valid = 1'b1;
    in_sel = 3'd2; in_data = 8'h22; tick();
    in_sel = 3'd5; in_data = 8'h55; tick();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 64'h24);
    check("pre_rst_data5", lane(5), 64'h55);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_valid", out_valid, 64'h00);
    check("mid_rst_data", out_data, 64'h0);
    check("mid_rst_ptr", rr_ptr, 64'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", out_valid, 64'h00);

    // Mixed modes
    out_ready = 8'hFF; in_valid = 1'b1;
    in_auto = 1'b1; in_data = 8'h40; tick();
    check("mix_ptr1", rr_ptr, 64'h1);
    check("mix_lane0", lane(0), 64'h40);
    in_auto = 1'b0; in_sel = 3'd6; in_data = 8'h41; tick();
    check("mix_ptr_hold", rr_ptr, 64'h1);
    check("mix_lane6_valid", out_valid, 64'h40);
    check("mix_lane6", lane(6), 64'h41);
    in_auto = 1'b1; in_data = 8'h42; tick();
    check("mix_lane1", lane(1), 64'h42);
    check("mix_valid", out_valid, 64'h02);
    check("mix_ptr2", rr_ptr, 64'h2);
    in_valid = 1'b0;
    tick();

`ifdef PE_DEMUX_BCAST_EN
    in_bcast = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1 check("bc_ready", in_ready, 64'h1);
    tick();
    check("bc_valid", out_valid, 64'hFF);
    check("bc_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("bc_ptr", rr_ptr, 64'h2);
    check("bc_fd", frame_done, 64'h0);
    in_valid = 1'b0; out_ready = 8'hEF;
    tick();
    check("bc_lane4_held", out_valid, 64'h10);
    in_valid = 1'b1; in_data = 8'h77;
    #1 check("bc_stall_ready", in_ready, 64'h0);
    tick();
    check("bc_stall_valid", out_valid, 64'h10);
    check("bc_stall_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b0; in_bcast = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
